// File: rtl/gesture_pkg.sv
// Shared types for the push-button gesture front-end: gesture codes and FSM states.
package gesture_pkg;

    typedef enum logic [1:0] {
        GEST_NONE   = 2'd0,
        GEST_TAP    = 2'd1,
        GEST_DOUBLE = 2'd2,
        GEST_LONG   = 2'd3
    } gesture_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESS1    = 3'd1,
        ST_WAIT_GAP  = 3'd2,
        ST_PRESS2    = 3'd3,
        ST_LONG_HELD = 3'd4
    } gesture_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stability counter turning the raw active-low button
// into a clean active-high pressed level.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic Clock,
    input  logic nReset,
    input  logic button,
    output logic pressed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_r;
    logic             sync_n_r;
    logic             pressed_r;
    logic [CNT_W-1:0] cnt_r;
    logic             differ_s;

    // sync_n is active-low, so equal values against the active-high level mean disagreement
    assign differ_s = (sync_n_r == pressed_r);
    assign pressed  = pressed_r;

    // Synchroniser chain, resets to the released level
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sync1_r  <= 1'b1;
            sync_n_r <= 1'b1;
        end else begin
            sync1_r  <= button;
            sync_n_r <= sync1_r;
        end
    end

    // Debounce counter and level flip once the input has disagreed long enough
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            cnt_r     <= '0;
            pressed_r <= 1'b0;
        end else if (differ_s) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r     <= '0;
                pressed_r <= ~pressed_r;
            end else begin
                cnt_r     <= cnt_r + CNT_ONE;
                pressed_r <= pressed_r;
            end
        end else begin
            cnt_r     <= '0;
            pressed_r <= pressed_r;
        end
    end

endmodule

// File: rtl/gesture_decoder.sv
// Classifies debounced button activity into TAP, DOUBLE and LONG gestures and
// reports each as a registered one-cycle event.
module gesture_decoder
    import gesture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LONG_CYCLES     = 1000,
    parameter int GAP_CYCLES      = 200
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       button,
    output logic       pressed,
    output logic       event_valid,
    output logic [1:0] event_code
);

    localparam int TIMER_W = $clog2(max_int(LONG_CYCLES, GAP_CYCLES)) + 1;
    localparam logic [TIMER_W-1:0] LONG_LAST = TIMER_W'(LONG_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = {TIMER_W{1'b1}};

    logic               pressed_s;
    gesture_state_t     state_r;
    gesture_state_t     state_next_s;
    logic [TIMER_W-1:0] timer_r;
    logic               emit_s;
    gesture_t           code_s;
    logic               event_valid_r;
    gesture_t           event_code_r;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .Clock  (Clock),
        .nReset (nReset),
        .button (button),
        .pressed(pressed_s)
    );

    assign pressed     = pressed_s;
    assign event_valid = event_valid_r;
    assign event_code  = event_code_r;

    // Next-state and event decision; release/press in an expiry cycle wins over the timeout
    always_comb begin
        state_next_s = state_r;
        emit_s       = 1'b0;
        code_s       = GEST_NONE;
        case (state_r)
            ST_IDLE: begin
                if (pressed_s) begin
                    state_next_s = ST_PRESS1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PRESS1: begin
                if (!pressed_s) begin
                    state_next_s = ST_WAIT_GAP;
                end else if (timer_r == LONG_LAST) begin
                    state_next_s = ST_LONG_HELD;
                    emit_s       = 1'b1;
                    code_s       = GEST_LONG;
                end else begin
                    state_next_s = ST_PRESS1;
                end
            end
            ST_WAIT_GAP: begin
                if (pressed_s) begin
                    state_next_s = ST_PRESS2;
                end else if (timer_r == GAP_LAST) begin
                    state_next_s = ST_IDLE;
                    emit_s       = 1'b1;
                    code_s       = GEST_TAP;
                end else begin
                    state_next_s = ST_WAIT_GAP;
                end
            end
            ST_PRESS2: begin
                if (!pressed_s) begin
                    state_next_s = ST_IDLE;
                    emit_s       = 1'b1;
                    code_s       = GEST_DOUBLE;
                end else begin
                    state_next_s = ST_PRESS2;
                end
            end
            ST_LONG_HELD: begin
                if (!pressed_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_LONG_HELD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, shared saturating timer and registered event outputs
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_r       <= ST_IDLE;
            timer_r       <= '0;
            event_valid_r <= 1'b0;
            event_code_r  <= GEST_NONE;
        end else begin
            state_r       <= state_next_s;
            event_valid_r <= emit_s;
            event_code_r  <= code_s;
            if (state_next_s != state_r) begin
                timer_r <= '0;
            end else if (timer_r != TIMER_MAX) begin
                timer_r <= timer_r + TIMER_ONE;
            end else begin
                timer_r <= timer_r;
            end
        end
    end

endmodule

// File: tb/tb_gesture_decoder.sv
// Directed self-checking bench for gesture_decoder with short timing parameters.
module tb_gesture_decoder;

    logic       Clock = 1'b0;
    logic       nReset;
    logic       button;
    logic       pressed;
    logic       event_valid;
    logic [1:0] event_code;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int ev_count = 0;
    int ev_cyc   = 0;
    int rise_cyc = 0;
    int fall_cyc = 0;
    int rise_n   = 0;
    int code_err = 0;
    logic [1:0] ev_code = 2'd0;
    logic prev_pressed = 1'b0;

    gesture_decoder #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20),
        .GAP_CYCLES     (10)
    ) dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .button     (button),
        .pressed    (pressed),
        .event_valid(event_valid),
        .event_code (event_code)
    );

    always #5 Clock = ~Clock;

    task automatic check_value(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock, sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
        if (event_valid === 1'b1) begin
            ev_count++;
            ev_cyc  = cyc;
            ev_code = event_code;
        end else if (event_code !== 2'd0) begin
            code_err++;
        end
        if (pressed && !prev_pressed) begin
            rise_cyc = cyc;
            rise_n++;
        end
        if (!pressed && prev_pressed) begin
            fall_cyc = cyc;
        end
        prev_pressed = pressed;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    task automatic clear_ev();
        ev_count = 0;
        ev_cyc   = 0;
        ev_code  = 2'd0;
    endtask

    task automatic press_for(input int low_cycles, input int high_cycles);
        button = 1'b0;
        ticks(low_cycles);
        button = 1'b1;
        ticks(high_cycles);
    endtask

    initial begin
        int lat;
        int rise_before;

        // 1: reset state, then a button held through reset release
        nReset = 1'b0;
        button = 1'b0;
        #2;
        ticks(3);
        check_value("rst_pressed", int'(pressed), 0);
        check_value("rst_valid", int'(event_valid), 0);
        check_value("rst_code", int'(event_code), 0);
        nReset = 1'b1;
        ticks(5);
        check_value("rise_before_6", int'(pressed), 0);
        tick();
        check_value("rise_at_6", int'(pressed), 1);
        button = 1'b1;
        ticks(60);
        clear_ev();

        // 2: glitches of 1..3 cycles are filtered
        rise_before = rise_n;
        for (int w = 1; w <= 3; w++) begin
            press_for(w, 5);
        end
        ticks(10);
        check_value("glitch_rise", rise_n - rise_before, 0);
        check_value("glitch_events", ev_count, 0);

        // 3: single tap
        clear_ev();
        press_for(8, 60);
        check_value("tap_count", ev_count, 1);
        check_value("tap_code", int'(ev_code), 1);
        lat = ev_cyc - fall_cyc;
        check_value("tap_latency", int'(lat >= 10 && lat <= 11), 1);

        // 4: double tap
        clear_ev();
        press_for(6, 5);
        press_for(6, 40);
        check_value("double_count", ev_count, 1);
        check_value("double_code", int'(ev_code), 2);
        lat = ev_cyc - fall_cyc;
        check_value("double_after_fall", int'(lat >= 1 && lat <= 2), 1);

        // 5: long press, no repeat after release
        clear_ev();
        button = 1'b0;
        ticks(40);
        check_value("long_count", ev_count, 1);
        check_value("long_code", int'(ev_code), 3);
        lat = ev_cyc - rise_cyc;
        check_value("long_latency", int'(lat >= 20 && lat <= 21), 1);
        button = 1'b1;
        ticks(40);
        check_value("long_no_repeat", ev_count, 1);

        // 6: reset during the gap discards the pending tap
        clear_ev();
        press_for(8, 10);
        nReset = 1'b0;
        #1;
        check_value("midrst_valid", int'(event_valid), 0);
        ticks(2);
        nReset = 1'b1;
        ticks(40);
        check_value("midrst_events", ev_count, 0);
        check_value("midrst_pressed", int'(pressed), 0);
        clear_ev();
        press_for(8, 40);
        check_value("post_rst_tap_count", ev_count, 1);
        check_value("post_rst_tap_code", int'(ev_code), 1);

        check_value("code_none_when_idle", code_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
